// File: rtl/formula_1_isqrt_sched.sv
// Time-multiplexed evaluation of isqrt(a) + isqrt(b) + isqrt(c) through one shared
// pipelined isqrt: issues a, b, c on consecutive cycles and sums the in-order results.
module formula_1_isqrt_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    output logic        arg_rdy,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        sq_x_vld,
    output logic [31:0] sq_x,
    input  logic        sq_y_vld,
    input  logic [31:0] sq_y,
    output logic        res_vld,
    output logic [31:0] res
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE_A = 2'd1;
    localparam logic [1:0] ISSUE_B = 2'd2;
    localparam logic [1:0] ISSUE_C = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        accept;
    logic [31:0] cap_b;
    logic [31:0] cap_c;
    logic [1:0]  cnt;
    logic [31:0] acc;

    // Ready depends on state only, so a new set can follow ISSUE_C with no bubble.
    assign arg_rdy  = (state == IDLE) || (state == ISSUE_C);
    assign accept   = arg_vld && arg_rdy;
    assign sq_x_vld = (state != IDLE);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE_A;
            ISSUE_A: state_nxt = ISSUE_B;
            ISSUE_B: state_nxt = ISSUE_C;
            ISSUE_C: state_nxt = accept ? ISSUE_A : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The sq_x register itself captures a on accept; b and c wait in capture registers.
    // Nothing here loads outside accept or an issue step, so sq_x holds still in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_b <= '0;
            cap_c <= '0;
            sq_x  <= '0;
        end else begin
            if (accept) begin
                cap_b <= b;
                cap_c <= c;
                sq_x  <= a;
            end else if (state == ISSUE_A) begin
                sq_x  <= cap_b;
            end else if (state == ISSUE_B) begin
                sq_x  <= cap_c;
            end
        end
    end

    // Results return in issue order, so a modulo-3 count is enough to frame each set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 2'd0;
            acc     <= '0;
            res     <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            if (sq_y_vld) begin
                case (cnt)
                    2'd0: begin
                        acc <= sq_y;
                        cnt <= 2'd1;
                    end
                    2'd1: begin
                        acc <= acc + sq_y;
                        cnt <= 2'd2;
                    end
                    default: begin
                        res     <= acc + sq_y;
                        res_vld <= 1'b1;
                        cnt     <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_formula_1_isqrt_sched.sv
// Directed bench for formula_1_isqrt_sched with a behavioural pipelined isqrt of latency L.
module tb_formula_1_isqrt_sched;

    localparam int L = 4;

    logic        clk;
    logic        rst;
    logic        arg_vld;
    logic        arg_rdy;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        sq_x_vld;
    logic [31:0] sq_x;
    logic        sq_y_vld;
    logic [31:0] sq_y;
    logic        res_vld;
    logic [31:0] res;

    int n_checks;
    int n_fail;
    int cyc;

    logic [31:0] got_res[$];
    int          got_cyc[$];
    logic [31:0] prev_sq_x;
    logic        prev_res_vld;

    logic        pv[L];
    logic [31:0] pd[L];

    formula_1_isqrt_sched dut (
        .clk      (clk),
        .rst      (rst),
        .arg_vld  (arg_vld),
        .arg_rdy  (arg_rdy),
        .a        (a),
        .b        (b),
        .c        (c),
        .sq_x_vld (sq_x_vld),
        .sq_x     (sq_x),
        .sq_y_vld (sq_y_vld),
        .sq_y     (sq_y),
        .res_vld  (res_vld),
        .res      (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] isqrt_ref(input logic [31:0] x);
        longint r;
        longint t;
        r = 0;
        for (int i = 15; i >= 0; i--) begin
            t = r + (longint'(1) << i);
            if (t * t <= longint'(x)) r = t;
        end
        return 32'(r);
    endfunction

    // Shared isqrt stand-in, reset by the same rst as the scheduler.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= sq_x_vld;
            pd[0] <= isqrt_ref(sq_x);
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign sq_y_vld = pv[L-1];
    assign sq_y     = pd[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Result capture plus continuous checks on sq_x stability and pulse width.
    always @(negedge clk) begin
        if (rst) begin
            prev_sq_x    <= sq_x;
            prev_res_vld <= 1'b0;
        end else begin
            if (res_vld) begin
                got_res.push_back(res);
                got_cyc.push_back(cyc);
            end
            if (!sq_x_vld) begin
                n_checks++;
                if (sq_x !== prev_sq_x) begin
                    n_fail++;
                    $display("FAIL sq_x_idle_stable at cycle %0d: got %0d, required %0d", cyc, sq_x, prev_sq_x);
                end
            end
            if (res_vld) begin
                n_checks++;
                if (prev_res_vld) begin
                    n_fail++;
                    $display("FAIL res_vld_single_pulse at cycle %0d: got high two cycles running, required one-cycle pulse", cyc);
                end
            end
            prev_sq_x    <= sq_x;
            prev_res_vld <= res_vld;
        end
    end

    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] xc,
                        output int acc_cyc);
        int n;
        a = xa;
        b = xb;
        c = xc;
        arg_vld = 1'b1;
        n = 0;
        while (!arg_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (arg_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL send_rdy_timeout: arg_rdy got %b, required 1 within 20 cycles", arg_rdy);
        end
        @(negedge clk);
        acc_cyc = cyc;
        arg_vld = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (got_res.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (got_res.size() < n) begin
            n_fail++;
            $display("FAIL wait_results_timeout: got %0d results, required %0d", got_res.size(), n);
        end
    endtask

    task automatic flush();
        got_res.delete();
        got_cyc.delete();
    endtask

    task automatic check_outputs_reset(input string tag);
        n_checks++;
        if ({arg_rdy, sq_x_vld, res_vld} !== 3'b100 || sq_x !== 32'd0 || res !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b xv=%b x=%0d rv=%b res=%0d, required rdy=1 xv=0 x=0 rv=0 res=0",
                     tag, arg_rdy, sq_x_vld, sq_x, res_vld, res);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arg_vld = 1'b0;
        a = '0;
        b = '0;
        c = '0;
        #12;
        check_outputs_reset("reset_values");
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_outputs_reset("after_reset_release");
    endtask

    task automatic test_single();
        int t;
        logic [31:0] exp_x[3];
        exp_x[0] = 32'd16;
        exp_x[1] = 32'd25;
        exp_x[2] = 32'd36;
        flush();
        send(32'd16, 32'd25, 32'd36, t);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (sq_x_vld !== 1'b1 || sq_x !== exp_x[i]) begin
                n_fail++;
                $display("FAIL single_issue_%0d: got vld=%b x=%0d, required vld=1 x=%0d", i, sq_x_vld, sq_x, exp_x[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (sq_x_vld !== 1'b0 || sq_x !== 32'd36) begin
            n_fail++;
            $display("FAIL single_issue_end: got vld=%b x=%0d, required vld=0 x=36", sq_x_vld, sq_x);
        end
        wait_results(1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (got_res.size() != 1 || got_res[0] !== 32'd15 || got_cyc[0] != t + L + 3) begin
            n_fail++;
            $display("FAIL single_result: got count=%0d res=%0d at edge +%0d, required count=1 res=15 at edge +%0d",
                     got_res.size(), (got_res.size() > 0) ? got_res[0] : 32'd0,
                     (got_cyc.size() > 0) ? got_cyc[0] - t : -1, L + 3);
        end
    endtask

    task automatic test_extremes();
        int t;
        flush();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
        wait_results(1);
        n_checks++;
        if (got_res.size() < 1 || got_res[0] !== 32'd196605) begin
            n_fail++;
            $display("FAIL extreme_max: got %0d, required 196605", (got_res.size() > 0) ? got_res[0] : 32'd0);
        end
        flush();
        send(32'd0, 32'd0, 32'd0, t);
        wait_results(1);
        n_checks++;
        if (got_res.size() < 1 || got_res[0] !== 32'd0 || res !== 32'd0) begin
            n_fail++;
            $display("FAIL extreme_zero: got %0d, required 0", (got_res.size() > 0) ? got_res[0] : 32'hDEAD);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[3];
        logic [31:0] vb[3];
        logic [31:0] vc[3];
        logic [31:0] exp_res[3];
        int idx;
        va[0] = 32'd1;   vb[0] = 32'd4;   vc[0] = 32'd9;   exp_res[0] = 32'd6;
        va[1] = 32'd100; vb[1] = 32'd100; vc[1] = 32'd100; exp_res[1] = 32'd30;
        va[2] = 32'd2;   vb[2] = 32'd3;   vc[2] = 32'd8;   exp_res[2] = 32'd4;
        flush();
        idx = 0;
        a = va[0];
        b = vb[0];
        c = vc[0];
        arg_vld = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 7) begin
                n_checks++;
                if (arg_rdy !== ((k % 3) == 0)) begin
                    n_fail++;
                    $display("FAIL b2b_rdy_pattern[%0d]: got %b, required %b", k, arg_rdy, (k % 3) == 0);
                end
            end
            if (k > 0) begin
                n_checks++;
                if (sq_x_vld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_issue_gap[%0d]: sq_x_vld got %b, required 1", k, sq_x_vld);
                end
            end
            if (arg_rdy && arg_vld) begin
                @(negedge clk);
                idx++;
                if (idx < 3) begin
                    a = va[idx];
                    b = vb[idx];
                    c = vc[idx];
                end else begin
                    arg_vld = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
        wait_results(3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got_res.size() <= i || got_res[i] !== exp_res[i]) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got %0d, required %0d", i, (got_res.size() > i) ? got_res[i] : 32'd0, exp_res[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (got_cyc.size() <= i || got_cyc[i] - got_cyc[i-1] != 3) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 3", i,
                         (got_cyc.size() > i) ? got_cyc[i] - got_cyc[i-1] : -1);
            end
        end
    endtask

    task automatic test_random_gaps();
        logic [31:0] exp_q[$];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rc;
        int t;
        flush();
        for (int s = 0; s < 20; s++) begin
            ra = $urandom();
            rb = $urandom();
            rc = $urandom();
            exp_q.push_back(isqrt_ref(ra) + isqrt_ref(rb) + isqrt_ref(rc));
            send(ra, rb, rc, t);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_results(20);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (got_res.size() <= i || got_res[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_result[%0d]: got %0d, required %0d", i, (got_res.size() > i) ? got_res[i] : 32'd0, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        flush();
        send(32'd400, 32'd400, 32'd400, t);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_outputs_reset("mid_reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs_reset("mid_reset_held");
        #1 rst = 1'b0;
        @(negedge clk);
        repeat (L + 10) @(negedge clk);
        n_checks++;
        if (got_res.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_aborted: got %0d results (first %0d), required 0", got_res.size(), got_res[0]);
        end
        send(32'd81, 32'd0, 32'd1, t);
        wait_results(1);
        repeat (10) @(negedge clk);
        n_checks++;
        if (got_res.size() != 1 || got_res[0] !== 32'd10) begin
            n_fail++;
            $display("FAIL mid_reset_recover: got count=%0d res=%0d, required count=1 res=10",
                     got_res.size(), (got_res.size() > 0) ? got_res[0] : 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
